// File: rtl/dice_pkg.sv
// Shared types and constants for the coin-driven die roller and its consumers.
package dice_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Legacy face-to-colour codes still used by downstream game logic.
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] RED  = 2'd1;
  localparam logic [1:0] BLUE = 2'd2;

  localparam int SIDES_MIN = 2;
  localparam int SIDES_MAX = 256;
  localparam int RETRY_MAX = 15;

endpackage

// File: rtl/coin_die_roller.sv
// Turns a stream of coin flips into a uniform face 1..SIDES using MSB-first
// draws with rejection sampling and a bounded number of redraws per roll.
//
// state   | meaning
// IDLE    | waiting for start; coin bits ignored
// COLLECT | shifting coin bits into the current draw
module coin_die_roller
  import dice_pkg::*;
#(
  parameter  int SIDES     = 6,
  parameter  int MAX_RETRY = 3,
  localparam int W         = $clog2(SIDES),
  localparam int RW        = $clog2(SIDES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          coin_valid,
  input  logic          coin,
  output logic          busy,
  output logic          result_valid,
  output logic [RW-1:0] result,
  output logic          fail,
  output logic [3:0]    retries
);

  localparam int             CW        = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(W - 1);
  localparam logic [W:0]     SIDES_X   = (W + 1)'(SIDES);
  localparam logic [3:0]     RETRY_LIM = 4'(MAX_RETRY);

  if (SIDES < SIDES_MIN || SIDES > SIDES_MAX) begin : g_bad_sides
    $error("coin_die_roller: SIDES outside legal range");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > RETRY_MAX) begin : g_bad_retry
    $error("coin_die_roller: MAX_RETRY outside legal range");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  draw_q, draw_d, draw_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d;
  logic [RW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          fail_q, fail_d;
  logic          in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      draw_q         <= '0;
      cnt_q          <= '0;
      retries_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      draw_q         <= draw_d;
      cnt_q          <= cnt_d;
      retries_q      <= retries_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      fail_q         <= fail_d;
    end
  end

  always_comb begin
    // Widened compare keeps SIDES = 2^W from truncating to zero.
    draw_nxt       = W'({draw_q, coin});
    in_range       = {1'b0, draw_nxt} < SIDES_X;
    state_d        = state_q;
    draw_d         = draw_q;
    cnt_d          = cnt_q;
    retries_d      = retries_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    fail_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          draw_d    = '0;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      COLLECT: begin
        if (start) begin
          draw_d    = '0;
          cnt_d     = '0;
          retries_d = '0;
        end else if (coin_valid) begin
          draw_d = draw_nxt;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (in_range) begin
              result_d       = RW'(draw_nxt) + RW'(1);
              result_valid_d = 1'b1;
              state_d        = IDLE;
            end else if (retries_q < RETRY_LIM) begin
              retries_d = retries_q + 4'd1;
            end else begin
              fail_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == COLLECT);
    result_valid = result_valid_q;
    result       = result_q;
    fail         = fail_q;
    retries      = retries_q;
  end

endmodule

// File: tb/tb_coin_die_roller.sv
// Randomised bench for coin_die_roller: a six-sided/2-retry instance and an
// eight-sided instance, checked against a draw-level model of rejection sampling.
module tb_coin_die_roller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, cv_a, coin_a, busy_a, rv_a, fail_a;
  logic [2:0] res_a;
  logic [3:0] rtr_a;
  logic start_b, cv_b, coin_b, busy_b, rv_b, fail_b;
  logic [3:0] res_b;
  logic [3:0] rtr_b;

  coin_die_roller #(.SIDES(6), .MAX_RETRY(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .coin_valid(cv_a), .coin(coin_a),
    .busy(busy_a), .result_valid(rv_a), .result(res_a), .fail(fail_a), .retries(rtr_a)
  );

  coin_die_roller #(.SIDES(8), .MAX_RETRY(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .coin_valid(cv_b), .coin(coin_b),
    .busy(busy_b), .result_valid(rv_b), .result(res_b), .fail(fail_b), .retries(rtr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;
  int last_res[2];
  int hist[9];

  logic        o_busy, o_rv, o_fail;
  logic [31:0] o_res, o_rtr;

  always_comb begin
    if (cur == 1) begin
      o_busy = busy_b; o_rv = rv_b; o_fail = fail_b;
      o_res  = 32'(res_b); o_rtr = 32'(rtr_b);
    end else begin
      o_busy = busy_a; o_rv = rv_a; o_fail = fail_a;
      o_res  = 32'(res_a); o_rtr = 32'(rtr_a);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (dut %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  task automatic drive(input bit st, input bit cv, input bit c);
    if (cur == 1) begin
      start_b = st; cv_b = cv; coin_b = c;
    end else begin
      start_a = st; cv_a = cv; coin_a = c;
    end
  endtask

  task automatic feed(input bit c);
    drive(0, 1, c);
    @(negedge clk);
    drive(0, 0, 0);
  endtask

  // Model works per draw: each draw is a W-bit integer; in-range ends the roll,
  // out-of-range costs a retry until the budget is spent.
  task automatic roll(input int draws[$], input bit gaps);
    int sides, mr, rtr, v;
    bit done;
    sides = (cur == 1) ? 8 : 6;
    mr    = (cur == 1) ? 3 : 2;
    rtr   = 0;
    done  = 0;
    @(negedge clk); drive(1, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    check("busy_after_start", 32'(o_busy), 1);
    check("retries_cleared", o_rtr, 0);
    foreach (draws[k]) begin
      if (!done) begin
        v = draws[k];
        for (int b = 2; b >= 0; b--) begin
          if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
          feed(v[b]);
        end
        if (v < sides) begin
          check("valid", 32'(o_rv), 1);
          check("valid_no_fail", 32'(o_fail), 0);
          check("result", o_res, 32'(v + 1));
          check("retries_at_result", o_rtr, 32'(rtr));
          check("busy_after_result", 32'(o_busy), 0);
          last_res[cur] = v + 1;
          if (cur == 1 && o_res <= 8) hist[o_res]++;
          done = 1;
        end else if (rtr < mr) begin
          rtr++;
          check("reject_no_pulse", 32'(o_rv | o_fail), 0);
          check("reject_busy", 32'(o_busy), 1);
          check("reject_retries", o_rtr, 32'(rtr));
        end else begin
          check("fail", 32'(o_fail), 1);
          check("fail_no_valid", 32'(o_rv), 0);
          check("fail_result_held", o_res, 32'(last_res[cur]));
          check("fail_retries", o_rtr, 32'(rtr));
          check("busy_after_fail", 32'(o_busy), 0);
          done = 1;
        end
      end
    end
    @(negedge clk);
    check("pulse_one_cycle", 32'(o_rv | o_fail), 0);
    check("result_hold", o_res, 32'(last_res[cur]));
    check("retries_hold", o_rtr, 32'(rtr));
  endtask

  initial begin
    int q[$];
    rst = 1'b0;
    start_a = 0; cv_a = 0; coin_a = 0;
    start_b = 0; cv_b = 0; coin_b = 0;
    last_res[0] = 0; last_res[1] = 0;
    for (int i = 0; i < 9; i++) hist[i] = 0;

    #1;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      #1;
      check("rst_busy", 32'(o_busy), 0);
      check("rst_valid", 32'(o_rv), 0);
      check("rst_fail", 32'(o_fail), 0);
      check("rst_result", o_res, 0);
      check("rst_retries", o_rtr, 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    cur = 0;
    q = '{5};       roll(q, 0);
    q = '{6, 2};    roll(q, 0);
    q = '{7, 7, 7}; roll(q, 0);
    cur = 1;
    q = '{7};       roll(q, 0);

    // Restart mid-roll: bits 1,1 and the coin alongside the second start are dropped.
    cur = 0;
    @(negedge clk); drive(1, 0, 0);
    @(negedge clk); drive(0, 1, 1);
    @(negedge clk); drive(0, 1, 1);
    @(negedge clk); drive(1, 1, 0);
    @(negedge clk); drive(0, 0, 0);
    check("restart_busy", 32'(o_busy), 1);
    check("restart_retries", o_rtr, 0);
    feed(0); feed(0); feed(1);
    check("restart_valid", 32'(o_rv), 1);
    check("restart_result", o_res, 2);
    // start coincident with result_valid is accepted
    drive(1, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    check("start_on_valid_busy", 32'(o_busy), 1);
    check("start_on_valid_pulse", 32'(o_rv), 0);
    feed(1); feed(0); feed(1);
    check("start_on_valid_result", o_res, 6);
    last_res[0] = 6;

    // Async reset mid-roll after one rejection and two further bits.
    @(negedge clk); drive(1, 0, 0);
    @(negedge clk); drive(0, 0, 0);
    feed(1); feed(1); feed(1);
    check("pre_reset_retries", o_rtr, 1);
    feed(1); feed(1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 0);
    check("async_rst_result", o_res, 0);
    check("async_rst_retries", o_rtr, 0);
    check("async_rst_pulse", 32'(o_rv | o_fail), 0);
    last_res[0] = 0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, i[0]);
      @(negedge clk);
      check("nostart_busy", 32'(o_busy), 0);
      check("nostart_valid", 32'(o_rv), 0);
    end
    drive(0, 0, 0);

    for (int d = 0; d < 2; d++) begin
      cur = d;
      for (int r = 0; r < 1200; r++) begin
        q.delete();
        for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 7)));
        roll(q, 1'($urandom_range(0, 1)));
      end
    end

    for (int f = 1; f <= 8; f++) begin
      check("hist_low", 32'(hist[f] >= 100), 1);
      check("hist_high", 32'(hist[f] <= 200), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_die_roller.md
# coin_die_roller

Parametrised successor to the fixed three-flip dice FSM. Turns a stream of externally supplied coin flips into a uniformly distributed face 1..SIDES of an N-sided die. It collects bits MSB-first and uses rejection sampling: out-of-range draws are discarded and redrawn. It sits between the coin/entropy source and the game-logic consumer, signals each roll with a one-cycle valid pulse and reports retry exhaustion as a failure.

## Interface
- SIDES, 6, number of die faces; legal range 2..256.
- MAX_RETRY, 3, rejected draws tolerated per roll before failure; legal range 0..15.
- Derived: W = $clog2(SIDES), the number of coin bits per draw. RW = $clog2(SIDES+1), the result width.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new roll; also aborts and restarts a roll in progress.
- coin_valid  in  1  coin bit on `coin` is valid this cycle.
- coin  in  1  coin flip value.
- busy  out  1  high while collecting bits (state COLLECT).
- result_valid  out  1  one-cycle pulse when `result` updates.
- result  out  RW  face value 1..SIDES; holds its value until the next result_valid.
- fail  out  1  one-cycle pulse when retries are exhausted; `result` is unchanged.
- retries  out  4  rejected draws in the current or last roll; holds its value until the next start.

## Operation
- States: IDLE, COLLECT.
- Reset values:
  - state = IDLE.
  - busy = 0, result_valid = 0, result = 0, fail = 0, retries = 0.
  - Internal shift register = 0, bit count = 0.
- IDLE:
  - coin_valid is ignored.
  - start → COLLECT. Clear the bit count, shift register and retries.
- COLLECT:
  - Each coin_valid shifts `coin` in at the LSB: draw = {draw[W-2:0], coin}. The first flip ends up as the MSB.
  - Increment the bit count.
  - Cycles without coin_valid hold all state; there is no timeout.
- On the cycle the W-th bit is accepted, evaluate v = the completed draw, including this cycle's bit:
  - v < SIDES: result ← v+1, result_valid ← 1, state → IDLE.
  - v ≥ SIDES and retries < MAX_RETRY: retries ← retries+1, clear the bit count, stay in COLLECT.
  - v ≥ SIDES and retries == MAX_RETRY: fail ← 1, state → IDLE.
- A power-of-two SIDES never rejects.
- start while in COLLECT restarts the roll:
  - Discard the partial draw, clear retries, stay in COLLECT.
  - A coin_valid in the same cycle as start is ignored.
- start in the same cycle as result_valid or fail, which is already IDLE next cycle, is accepted normally.
- Arithmetic:
  - Compare v against SIDES at W+1 bits to avoid truncation when SIDES = 2^W.
  - result = v+1 fits in RW bits.
- Reset asserted mid-roll returns to reset values immediately and asynchronously. No pulse is emitted.

## Timing
- start sampled at edge t → busy = 1 from t+1. Coin bits are accepted from edge t+1 onward.
- Final accepted bit at edge t → result_valid or fail high during t+1..t+2 (registered, exactly one cycle); busy = 0 from t+1.
- Minimum roll latency from start is W+1 edges at one coin per cycle. Each rejection adds W edges.
- result_valid and fail are never high together.

## Structure
- Shared package `dice_pkg`:
  - State enum (IDLE, COLLECT).
  - Legacy colour constants NONE/RED/BLUE, kept for consumers that map faces to colours.
  - Parameter-range constants SIDES_MIN = 2, SIDES_MAX = 256, RETRY_MAX = 15.
- Single module; no sub-module is warranted. Use elaboration-time assertions for the SIDES and MAX_RETRY ranges.

## Test plan
- SIDES=6: start, then coins 1,0,1 on consecutive cycles → result_valid one cycle after the third bit, result = 6, retries = 0.
- SIDES=6: coins 1,1,0 (v = 6, rejected) then 0,1,0 → result = 3, retries = 1, busy stays high throughout the rejection.
- SIDES=6, MAX_RETRY=2: coins 1,1,1 three times → fail pulse after the 9th bit, retries = 2, result unchanged from its previous value.
- SIDES=8: coins 1,1,1 → result = 8; random stimulus for 10k rolls yields no rejection and an approximately uniform histogram over 1..8.
- SIDES=6: start, coins 1,1, then start with coin_valid=1, coin=0 in the same cycle, then coins 0,0,1 → result = 2 (the earlier bits and the simultaneous bit are discarded).
- Reset: assert rst low after 2 coins of a roll → all outputs 0 immediately. After release, coin_valid pulses without start leave busy = 0 and produce no result_valid.
